// File: rtl/montgomery_4_pkg.sv
// Shared widths, iteration count and FSM encoding for the radix-4 Montgomery multiplier.
package montgomery_4_pkg;

  localparam int unsigned MONT_N     = 1024;
  localparam int unsigned MONT_W2    = MONT_N + 2;
  localparam int unsigned MONT_W3    = MONT_N + 3;
  localparam int unsigned MONT_ITERS = MONT_N / 2;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    LOOP,
    FINAL
  } state_e;

endpackage

// File: rtl/montgomery_4_step.sv
// One radix-4 Montgomery iteration: C' = (C + d*b + q*m) >> 2 with q chosen to clear the low two bits.
module mont_radix4_step
  import montgomery_4_pkg::*;
#(
  parameter int unsigned N = MONT_N
) (
  input  logic [N+2:0] c,
  input  logic [1:0]   d,
  input  logic [N-1:0] b,
  input  logic [N+1:0] b3,
  input  logic [N-1:0] m,
  input  logic [N+1:0] m3,
  output logic [N+2:0] c_next
);

  logic [N+2:0] db;
  logic [N+2:0] qm;
  logic [N+2:0] sum;
  logic [1:0]   t_lo;
  logic [1:0]   q;

  always_comb begin
    unique case (d)
      2'd0:    db = '0;
      2'd1:    db = {3'b000, b};
      2'd2:    db = {2'b00, b, 1'b0};
      default: db = {1'b0, b3};
    endcase

    // q depends only on T mod 4, so the full C + d*b is never resolved separately;
    // m^-1 == m (mod 4) for odd m.
    t_lo = c[1:0] + db[1:0];
    q    = 2'd0 - (t_lo * m[1:0]);

    unique case (q)
      2'd0:    qm = '0;
      2'd1:    qm = {3'b000, m};
      2'd2:    qm = {2'b00, m, 1'b0};
      default: qm = {1'b0, m3};
    endcase

    sum    = c + db + qm;
    c_next = sum >> 2;
  end

endmodule

// File: rtl/montgomery_4.sv
// Radix-4 Montgomery multiplier: result = a*b*2^-N mod m, two bits of a per cycle, pulse start/done.
module montgomery_4
  import montgomery_4_pkg::*;
#(
  parameter int unsigned N = MONT_N
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic [N-1:0] result,
  output logic         done
);

  localparam int unsigned   CW     = $clog2(N / 2);
  localparam logic [CW-1:0] LAST_I = CW'(N / 2 - 1);

  state_e       state_q, state_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;
  logic [N-1:0] m_q, m_d;
  logic [N+1:0] b3_q, b3_d;
  logic [N+1:0] m3_q, m3_d;
  logic [N+2:0] c_q, c_d;
  logic [N+2:0] c_step;
  logic [CW-1:0] i_q, i_d;
  logic [N-1:0] result_q, result_d;
  logic         done_q, done_d;

  mont_radix4_step #(.N(N)) u_step (
    .c      (c_q),
    .d      (a_q[1:0]),
    .b      (b_q),
    .b3     (b3_q),
    .m      (m_q),
    .m3     (m3_q),
    .c_next (c_step)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    b3_d     = b3_q;
    m3_d     = m3_q;
    c_d      = c_q;
    i_d      = i_q;
    result_d = result_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = in_a;
          b_d     = in_b;
          m_d     = in_m;
          state_d = PRE;
        end
      end
      PRE: begin
        b3_d    = {1'b0, b_q, 1'b0} + {2'b00, b_q};
        m3_d    = {1'b0, m_q, 1'b0} + {2'b00, m_q};
        c_d     = '0;
        i_d     = '0;
        state_d = LOOP;
      end
      LOOP: begin
        // a is consumed from the bottom, so the current digit is always a_q[1:0].
        c_d = c_step;
        a_d = a_q >> 2;
        i_d = i_q + CW'(1);
        if (i_q == LAST_I) begin
          state_d = FINAL;
        end
      end
      FINAL: begin
        result_d = N'((c_q >= {3'b000, m_q}) ? (c_q - {3'b000, m_q}) : c_q);
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      b3_q     <= '0;
      m3_q     <= '0;
      c_q      <= '0;
      i_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      b3_q     <= b3_d;
      m3_q     <= m3_d;
      c_q      <= c_d;
      i_q      <= i_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_montgomery_4.sv
// Directed-vector bench for montgomery_4: results, 514-cycle latency, done pulse shape, start and reset corners.
module tb_montgomery_4;
  import montgomery_4_pkg::*;

  localparam int unsigned N       = MONT_N;
  localparam int unsigned LAT     = 514;
  localparam int unsigned TIMEOUT = 1000;
  localparam int unsigned NVEC    = 9;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] m;
    logic [N-1:0] exp;
  } vec_t;

  logic         clk;
  logic         resetn;
  logic         start;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic [N-1:0] in_m;
  logic [N-1:0] result;
  logic         done;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  montgomery_4 #(.N(N)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .in_a   (in_a),
    .in_b   (in_b),
    .in_m   (in_m),
    .result (result),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got (low 128 bits) %h, required (low 128 bits) %h", name, act[127:0], exp[127:0]);
    end
  endtask

  // Called away from a clock edge; returns #1 after the edge that samples start.
  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] m);
    in_a  = a;
    in_b  = b;
    in_m  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    in_a  = {32{32'hdeadbeef}};
    in_b  = {32{32'h12345678}};
    in_m  = '0;
  endtask

  task automatic wait_done(output int unsigned lat, input int unsigned inject_at);
    lat = 0;
    while (lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
      start = 1'b0;
      if (done) break;
      if (inject_at != 0 && lat == inject_at) begin
        start = 1'b1;
        in_a  = N'(7);
        in_b  = N'(9);
        in_m  = N'(11);
      end
    end
  endtask

  task automatic count_dones(input int unsigned ncyc, output int unsigned cnt);
    cnt = 0;
    for (int unsigned k = 0; k < ncyc; k++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
  endtask

  initial begin
    vec_t         vecs [NVEC];
    logic [N-1:0] ones;
    logic [N-1:0] p512;
    logic [N-1:0] p1023;
    logic [N-1:0] held;
    int unsigned  lat;
    int unsigned  cnt;

    ones  = '1;
    p512  = N'(1) << 512;
    p1023 = N'(1) << 1023;

    vecs[0] = '{a: N'(1),      b: N'(5),      m: ones,     exp: N'(5)};
    vecs[1] = '{a: ones - 1,   b: ones - 1,   m: ones,     exp: N'(1)};
    vecs[2] = '{a: '0,         b: N'(12345),  m: ones,     exp: '0};
    vecs[3] = '{a: N'(3),      b: N'(5),      m: N'(7),    exp: N'(4)};
    vecs[4] = '{a: N'(2),      b: N'(2),      m: N'(3),    exp: N'(1)};
    vecs[5] = '{a: p512 >> 1,  b: N'(4),      m: p512 + 1, exp: p512 - 1};
    vecs[6] = '{a: p1023,      b: N'(6),      m: ones,     exp: N'(3)};
    vecs[7] = '{a: N'(200),    b: N'(100),    m: N'(255),  exp: N'(110)};
    vecs[8] = '{a: N'(3),      b: ones - 1,   m: ones,     exp: ones - 3};

    resetn = 1'b0;
    start  = 1'b0;
    in_a   = '0;
    in_b   = '0;
    in_m   = '0;
    repeat (3) @(negedge clk);
    check("reset done", N'(done), '0);
    check("reset result", result, '0);
    resetn = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      launch(vecs[i].a, vecs[i].b, vecs[i].m);
      wait_done(lat, 0);
      check($sformatf("vec%0d latency", i), N'(lat), N'(LAT));
      check($sformatf("vec%0d result", i), result, vecs[i].exp);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d done width", i), N'(done), '0);
      check($sformatf("vec%0d result hold", i), result, vecs[i].exp);
    end

    // Start pulse mid-LOOP must be ignored.
    @(negedge clk);
    launch(vecs[0].a, vecs[0].b, vecs[0].m);
    wait_done(lat, 100);
    check("ignored start latency", N'(lat), N'(LAT));
    check("ignored start result", result, N'(5));
    count_dones(600, cnt);
    check("ignored start extra done", N'(cnt), '0);
    check("ignored start result hold", result, N'(5));

    // Start in the done cycle begins a second operation immediately.
    @(negedge clk);
    launch(N'(3), N'(7), ones);
    wait_done(lat, 0);
    check("b2b first latency", N'(lat), N'(LAT));
    check("b2b first result", result, N'(21));
    launch(vecs[3].a, vecs[3].b, vecs[3].m);
    wait_done(lat, 0);
    check("b2b second latency", N'(lat), N'(LAT));
    check("b2b second result", result, N'(4));

    // Reset around LOOP iteration 200.
    @(negedge clk);
    launch(vecs[7].a, vecs[7].b, vecs[7].m);
    repeat (202) @(posedge clk);
    #1;
    held = result;
    check("pre-reset result", held, N'(4));
    resetn = 1'b0;
    #1;
    check("mid-op reset done", N'(done), '0);
    check("mid-op reset result", result, '0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    count_dones(600, cnt);
    check("reset aborted done", N'(cnt), '0);
    check("reset result stays", result, '0);
    @(negedge clk);
    launch(vecs[7].a, vecs[7].b, vecs[7].m);
    wait_done(lat, 0);
    check("post-reset latency", N'(lat), N'(LAT));
    check("post-reset result", result, N'(110));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
